gbuff_arbiter: RTL and testbench

Round-robin arbiter with bounded burst locking that shares the single-port global buffer among NUM_REQ requesters, e.g. the host/CFU loader, the systolic-array operand fetch and the result writeback. Each requester issues one read or write per accepted beat over a valid/ready handshake. The arbiter drives the buffer's wr_en/index/data_in and routes the buffer's registered data_out back to the requester that issued the read.

---
 rtl/gbuff_arbiter_pkg.sv | 13 +
 rtl/gbuff_arbiter_rr_pick.sv | 28 ++
 rtl/gbuff_arbiter.sv | 91 +++++++++
 tb/tb_gbuff_arbiter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/gbuff_arbiter_pkg.sv
// Shared definitions for the global-buffer arbiter and the buffer itself.
// Holds default buffer geometry and the arbiter lock-state encoding.
package gbuff_arbiter_pkg;

  localparam int unsigned GBUF_ADDR_BITS = 8;
  localparam int unsigned GBUF_DATA_BITS = 8;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_e;

endpackage

// File: rtl/gbuff_arbiter_rr_pick.sv
// Combinational find-first-set over the valid vector, scanning from ptr_i
// upward with wrap-around; returns the winning index and an any-valid flag.
module rr_pick #(
  parameter  int unsigned NUM_REQ  = 3,
  localparam int unsigned PTR_BITS = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  valid_i,
  input  logic [PTR_BITS-1:0] ptr_i,
  output logic [PTR_BITS-1:0] idx_o,
  output logic                any_o
);

  int unsigned j;

  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      j = (int'(ptr_i) + i) % NUM_REQ;
      if (!any_o && valid_i[j]) begin
        any_o = 1'b1;
        idx_o = j[PTR_BITS-1:0];
      end
    end
  end

endmodule

// File: rtl/gbuff_arbiter.sv
// Round-robin arbiter with bounded burst locking in front of the single-port
// global buffer; routes the registered read data back to the issuing requester.
module gbuff_arbiter
  import gbuff_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 3,
  parameter int unsigned ADDR_BITS = GBUF_ADDR_BITS,
  parameter int unsigned DATA_BITS = GBUF_DATA_BITS,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ*ADDR_BITS-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [DATA_BITS-1:0]           rsp_data,
  output logic                           buf_wr_en,
  output logic [ADDR_BITS-1:0]           buf_index,
  output logic [DATA_BITS-1:0]           buf_data_in,
  input  logic [DATA_BITS-1:0]           buf_data_out
);

  localparam int unsigned PTR_BITS = $clog2(NUM_REQ);
  localparam int unsigned CNT_BITS = $clog2(MAX_BURST + 1);

  arb_state_e            state_q;
  logic [PTR_BITS-1:0]   ptr_q;
  logic [PTR_BITS-1:0]   owner_q;
  logic [CNT_BITS-1:0]   cnt_q;
  logic [NUM_REQ-1:0]    rsp_valid_q;
  logic [ADDR_BITS-1:0]  last_addr_q;

  logic [PTR_BITS-1:0]   pick_idx;
  logic                  pick_any;
  logic                  cont;
  logic                  granted;
  logic [PTR_BITS-1:0]   grant_idx;
  logic [ADDR_BITS-1:0]  sel_addr;
  logic [DATA_BITS-1:0]  sel_wdata;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .valid_i (req_valid),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  always_comb begin
    cont      = (state_q == ARB_LOCKED) && req_valid[owner_q] &&
                (cnt_q < CNT_BITS'(MAX_BURST));
    grant_idx = cont ? owner_q : pick_idx;
    granted   = cont || pick_any;
    sel_addr  = req_addr[grant_idx*ADDR_BITS +: ADDR_BITS];
    sel_wdata = req_wdata[grant_idx*DATA_BITS +: DATA_BITS];
    req_ready = granted ? (NUM_REQ'(1) << grant_idx) : '0;
    buf_wr_en = granted && req_we[grant_idx];
    // Idle cycles keep the last address so the buffer's dummy read is stable.
    buf_index   = granted ? sel_addr : last_addr_q;
    buf_data_in = sel_wdata;
    rsp_valid   = rsp_valid_q;
    rsp_data    = buf_data_out;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= '0;
      last_addr_q <= '0;
    end else begin
      rsp_valid_q <= (granted && !req_we[grant_idx]) ? req_ready : '0;
      if (granted) last_addr_q <= sel_addr;
      if (cont) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (pick_any) begin
        state_q <= ARB_LOCKED;
        owner_q <= pick_idx;
        cnt_q   <= CNT_BITS'(1);
        ptr_q   <= (pick_idx == PTR_BITS'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
      end else begin
        state_q <= ARB_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_gbuff_arbiter.sv
// Directed bench for gbuff_arbiter with a behavioural single-port buffer
// whose contents reload to index+1 on reset.
module tb_gbuff_arbiter;

  localparam int unsigned N  = 3;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_we    = '0;
  logic [N*AW-1:0] req_addr  = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            buf_wr_en;
  logic [AW-1:0]   buf_index;
  logic [DW-1:0]   buf_data_in;
  logic [DW-1:0]   buf_data_out;

  logic [DW-1:0]   mem [256];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  gbuff_arbiter #(
    .NUM_REQ   (N),
    .ADDR_BITS (AW),
    .DATA_BITS (DW),
    .MAX_BURST (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .buf_wr_en    (buf_wr_en),
    .buf_index    (buf_index),
    .buf_data_in  (buf_data_in),
    .buf_data_out (buf_data_out)
  );

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= DW'(i + 1);
      buf_data_out <= '0;
    end else begin
      if (buf_wr_en) mem[buf_index] <= buf_data_in;
      buf_data_out <= mem[buf_index];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]         = v;
    req_we[i]            = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    req_we    = '0;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_ready", 32'(req_ready), 32'h0);
    check_eq("rst_rsp",   32'(rsp_valid), 32'h0);
    check_eq("rst_wren",  32'(buf_wr_en), 32'h0);
    step();
    rst = 1'b0;

    // Req0 writes addr 5 = 0xAA, then reads it back
    set_req(0, 1'b1, 1'b1, 8'd5, 8'hAA);
    @(negedge clk);
    check_eq("wr_ready", 32'(req_ready),   32'h1);
    check_eq("wr_en",    32'(buf_wr_en),   32'h1);
    check_eq("wr_index", 32'(buf_index),   32'h5);
    check_eq("wr_data",  32'(buf_data_in), 32'hAA);
    step();
    set_req(0, 1'b1, 1'b0, 8'd5, 8'h00);
    @(negedge clk);
    check_eq("rd_ready", 32'(req_ready), 32'h1);
    check_eq("rd_wren",  32'(buf_wr_en), 32'h0);
    check_eq("rd_norsp", 32'(rsp_valid), 32'h0);
    step();
    set_req(0, 1'b0, 1'b0, 8'd0, 8'h00);
    @(negedge clk);
    check_eq("rd_rsp",       32'(rsp_valid), 32'h1);
    check_eq("rd_data",      32'(rsp_data),  32'hAA);
    check_eq("idle_ready",   32'(req_ready), 32'h0);
    check_eq("idle_index",   32'(buf_index), 32'h5);
    step();
    @(negedge clk);
    check_eq("idle_norsp", 32'(rsp_valid), 32'h0);
    step();

    // After reset, req1 reads addr 3 -> 0x04
    do_reset();
    set_req(1, 1'b1, 1'b0, 8'd3, 8'h00);
    @(negedge clk);
    check_eq("r1_ready", 32'(req_ready), 32'h2);
    step();
    set_req(1, 1'b0, 1'b0, 8'd0, 8'h00);
    @(negedge clk);
    check_eq("r1_rsp",  32'(rsp_valid), 32'h2);
    check_eq("r1_data", 32'(rsp_data),  32'h04);
    step();

    // Full contention, reads of addr 10+i (contents 11+i)
    do_reset();
    for (int i = 0; i < 3; i++) set_req(i, 1'b1, 1'b0, 8'(10 + i), 8'h00);
    begin
      int prev;
      prev = -1;
      for (int k = 0; k < 13; k++) begin
        int e;
        e = (k / 4) % 3;
        @(negedge clk);
        check_eq($sformatf("rr_grant%0d", k), 32'(req_ready), 32'(1 << e));
        if (prev >= 0) begin
          check_eq($sformatf("rr_rsp%0d", k),  32'(rsp_valid), 32'(1 << prev));
          check_eq($sformatf("rr_data%0d", k), 32'(rsp_data),  32'(11 + prev));
        end
        prev = e;
        step();
      end
    end

    // Req0 drops after 2 beats: 0,0,1,1,1,1,2
    do_reset();
    for (int i = 0; i < 3; i++) set_req(i, 1'b1, 1'b0, 8'(20 + i), 8'h00);
    begin
      int exp_seq [7] = '{0, 0, 1, 1, 1, 1, 2};
      for (int k = 0; k < 7; k++) begin
        if (k == 2) req_valid[0] = 1'b0;
        @(negedge clk);
        check_eq($sformatf("drop_grant%0d", k), 32'(req_ready), 32'(1 << exp_seq[k]));
        step();
      end
    end

    // Sole requester 2 re-granted every cycle across burst boundaries
    do_reset();
    set_req(2, 1'b1, 1'b1, 8'd40, 8'h55);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check_eq($sformatf("solo_grant%0d", k), 32'(req_ready), 32'h4);
      step();
    end

    // Reset right after a read accept drops the response
    do_reset();
    set_req(0, 1'b1, 1'b0, 8'd7, 8'h00);
    @(negedge clk);
    check_eq("rr_acc", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_eq("rr_rst_rsp", 32'(rsp_valid), 32'h0);
    step();
    rst = 1'b0;
    set_req(1, 1'b1, 1'b0, 8'd8, 8'h00);
    set_req(2, 1'b1, 1'b0, 8'd9, 8'h00);
    @(negedge clk);
    check_eq("rr_post_grant", 32'(req_ready), 32'h1);
    check_eq("rr_post_rsp",   32'(rsp_valid), 32'h0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
